// File: rtl/wr_arb_pkg.sv
// Shared types and default parameter values for the write-enable arbiter.
package wr_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_GUARD = 2'd2
  } arb_state_e;

  localparam int DEF_N_SRC     = 2;
  localparam int DEF_ADDR_W    = 4;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_GUARD_CYC = 1;
  localparam int DEF_MAX_HOLD  = 255;
  localparam int DEF_RR_EN     = 0;

  // Width of a counter that must hold values 0..max_val (never narrower than 1 bit).
  function automatic int cnt_w(input int max_val);
    cnt_w = (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/wr_arb_pick.sv
// Single-winner selector over the masked request vector: fixed priority
// (index 0 highest) or round-robin starting just after the last owner.
module wr_arb_pick
  import wr_arb_pkg::*;
#(
  parameter int N_SRC = DEF_N_SRC,
  parameter int RR_EN = DEF_RR_EN,
  localparam int PTR_W = cnt_w(N_SRC - 1)
) (
  input  logic [N_SRC-1:0] req_m,
  input  logic [PTR_W-1:0] last_ptr,
  output logic [N_SRC-1:0] gnt,
  output logic [PTR_W-1:0] gnt_idx,
  output logic             any
);

  logic [PTR_W:0]         shamt;
  logic [2*N_SRC-1:0]     dbl_req;
  logic [2*N_SRC-1:0]     dbl_oh;
  logic [N_SRC-1:0]       rot_req;
  logic [N_SRC-1:0]       rot_oh;
  logic [N_SRC-1:0]       fix_oh;
  logic [N_SRC-1:0]       rr_oh;

  // Isolate the lowest set bit (two's-complement trick).
  function automatic logic [N_SRC-1:0] lowest(input logic [N_SRC-1:0] v);
    lowest = v & (~v + 1'b1);
  endfunction

  // Round-robin is done by rotating the requests so the slot after last_ptr
  // lands at bit 0, picking the lowest bit, then rotating the winner back.
  always_comb begin
    shamt   = {1'b0, last_ptr} + 1'b1;
    dbl_req = {req_m, req_m} >> shamt;
    rot_req = dbl_req[N_SRC-1:0];
    rot_oh  = lowest(rot_req);
    dbl_oh  = {rot_oh, rot_oh} << shamt;
    rr_oh   = dbl_oh[2*N_SRC-1:N_SRC];
    fix_oh  = lowest(req_m);
    gnt     = (RR_EN != 0) ? rr_oh : fix_oh;
    any     = |req_m;
    gnt_idx = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (gnt[i]) begin
        gnt_idx = PTR_W'(i);
      end
    end
  end

endmodule

// File: rtl/wr_enable_arbiter.sv
// Grants exclusive register-bank write access to one of N_SRC sources,
// with guard gap between owners, hold-time limit and starvation mask.
module wr_enable_arbiter
  import wr_arb_pkg::*;
#(
  parameter int N_SRC     = DEF_N_SRC,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int GUARD_CYC = DEF_GUARD_CYC,
  parameter int MAX_HOLD  = DEF_MAX_HOLD,
  parameter int RR_EN     = DEF_RR_EN
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_SRC-1:0]        req,
  input  logic [N_SRC-1:0]        we,
  input  logic [N_SRC*ADDR_W-1:0] addr,
  input  logic [N_SRC*DATA_W-1:0] data,
  output logic [N_SRC-1:0]        grant,
  output logic                    we_out,
  output logic [ADDR_W-1:0]       addr_out,
  output logic [DATA_W-1:0]       data_out,
  output logic                    busy,
  output logic                    conflict,
  output logic                    timeout
);

  localparam int PTR_W  = cnt_w(N_SRC - 1);
  localparam int HOLD_W = cnt_w(MAX_HOLD);
  localparam int GRD_W  = cnt_w(GUARD_CYC);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [GRD_W-1:0]  GRD_LAST  = GRD_W'((GUARD_CYC > 0) ? GUARD_CYC - 1 : 0);
  localparam logic [PTR_W-1:0]  PTR_RST   = PTR_W'(N_SRC - 1);
  // With no guard gap the owner hands straight back to IDLE.
  localparam arb_state_e ST_RELEASE = (GUARD_CYC > 0) ? ST_GUARD : ST_IDLE;

  arb_state_e          state_q, state_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;   // current / last owner index
  logic [N_SRC-1:0]    grant_q, grant_d;
  logic                we_out_q, we_out_d;
  logic [ADDR_W-1:0]   addr_out_q, addr_out_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [GRD_W-1:0]    guard_q, guard_d;
  logic [N_SRC-1:0]    mask_q, mask_d;
  logic                conflict_q, conflict_d;
  logic                timeout_q, timeout_d;

  logic [N_SRC-1:0]    req_m;
  logic [N_SRC-1:0]    pick_gnt;
  logic [PTR_W-1:0]    pick_idx;
  logic                pick_any;
  logic                own_req;
  logic                own_we;
  logic [ADDR_W-1:0]   own_addr;
  logic [DATA_W-1:0]   own_data;
  logic                hold_hit;

  assign req_m = req & ~mask_q;

  wr_arb_pick #(
    .N_SRC (N_SRC),
    .RR_EN (RR_EN)
  ) u_pick (
    .req_m    (req_m),
    .last_ptr (rr_ptr_q),
    .gnt      (pick_gnt),
    .gnt_idx  (pick_idx),
    .any      (pick_any)
  );

  // Route the current owner's request, enable, address and data.
  always_comb begin
    own_req  = 1'b0;
    own_we   = 1'b0;
    own_addr = '0;
    own_data = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (rr_ptr_q == PTR_W'(i)) begin
        own_req  = req[i];
        own_we   = we[i];
        own_addr = addr[i*ADDR_W +: ADDR_W];
        own_data = data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign hold_hit = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);

  // Next-state and next-output logic; outputs are computed for the state
  // being entered so grant/we_out are never seen outside OWN.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = '0;
    we_out_d   = 1'b0;
    addr_out_d = addr_out_q;
    data_out_d = data_out_q;
    hold_d     = hold_q;
    guard_d    = guard_q;
    mask_d     = mask_q & req;   // a masked source is released once it drops req
    conflict_d = 1'b0;
    timeout_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d  = ST_OWN;
          rr_ptr_d = pick_idx;
          grant_d  = pick_gnt;
          hold_d   = '0;
        end
      end
      ST_OWN: begin
        conflict_d = |(we & ~grant_q);
        addr_out_d = own_addr;
        data_out_d = own_data;
        hold_d     = hold_q + 1'b1;
        if (!own_req) begin
          // Owner released; a write sampled with req low is dropped.
          state_d = ST_RELEASE;
          guard_d = '0;
        end else if (hold_hit) begin
          state_d   = ST_RELEASE;
          guard_d   = '0;
          timeout_d = 1'b1;
          mask_d    = mask_d | grant_q;
        end else begin
          grant_d  = grant_q;
          we_out_d = own_we;
        end
      end
      ST_GUARD: begin
        if (guard_q == GRD_LAST) begin
          state_d = ST_IDLE;
        end else begin
          guard_d = guard_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= PTR_RST;
      grant_q    <= '0;
      we_out_q   <= 1'b0;
      addr_out_q <= '0;
      data_out_q <= '0;
      hold_q     <= '0;
      guard_q    <= '0;
      mask_q     <= '0;
      conflict_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      we_out_q   <= we_out_d;
      addr_out_q <= addr_out_d;
      data_out_q <= data_out_d;
      hold_q     <= hold_d;
      guard_q    <= guard_d;
      mask_q     <= mask_d;
      conflict_q <= conflict_d;
      timeout_q  <= timeout_d;
    end
  end

  assign grant    = grant_q;
  assign we_out   = we_out_q;
  assign addr_out = addr_out_q;
  assign data_out = data_out_q;
  assign busy     = (state_q != ST_IDLE);
  assign conflict = conflict_q;
  assign timeout  = timeout_q;

endmodule
